// File: rtl/data_memory_mmio.sv
// Word-organised RV32 data RAM with byte/half/word lanes and a memory-mapped GPIO window.
// Build with `define GPIO_EDGE_IRQ_EN to add the GPIO edge-capture register and interrupt.
module data_memory_mmio #(
   parameter int                    DATA_WIDTH     = 32,
   parameter int                    MEMORY_DEPTH   = 1024,
   parameter int                    GPIO_WIDTH     = 8,
   parameter logic [15:0]           GPIO_BASE      = 16'h0024,
   parameter logic [GPIO_WIDTH-1:0] GPIO_RESET_VAL = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  Mem_Write_i,
   input  logic                  Mem_Read_i,
   input  logic [2:0]            Funct3_i,
   input  logic [DATA_WIDTH-1:0] Write_Data_i,
   input  logic [DATA_WIDTH-1:0] Address_i,
   input  logic [GPIO_WIDTH-1:0] gpio_port_in,
   output logic [DATA_WIDTH-1:0] Read_Data_o,
   output logic [GPIO_WIDTH-1:0] gpio_port_out,
   output logic                  Misaligned_o,
   output logic                  gpio_irq_o
);
   localparam int AW = $clog2(MEMORY_DEPTH);

   localparam logic [15:0] OUT_ADDR  = GPIO_BASE;
   localparam logic [15:0] SET_ADDR  = GPIO_BASE + 16'h0004;
   localparam logic [15:0] CLR_ADDR  = GPIO_BASE + 16'h0008;
   localparam logic [15:0] IN_ADDR   = GPIO_BASE + 16'h000C;
   localparam logic [15:0] EDGE_ADDR = GPIO_BASE + 16'h0010;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   logic [DATA_WIDTH-1:0] mem_q [MEMORY_DEPTH];

   logic [GPIO_WIDTH-1:0] gpio_out_q, gpio_out_d;
   logic [GPIO_WIDTH-1:0] sync1_q, sync1_d;
   logic [GPIO_WIDTH-1:0] sync2_q, sync2_d;
   logic [GPIO_WIDTH-1:0] edge_rd;

   logic [AW-1:0]         word_idx;
   logic [13:0]           win_word;
   logic                  hit_out, hit_set, hit_clr, hit_in, hit_edge, win_hit;
   logic                  load_ok, store_ok, load_mis, store_mis;
   logic                  gpio_wr;
   logic [DATA_WIDTH-1:0] rd_word;
   logic [7:0]            rd_byte;
   logic [15:0]           rd_half;
   logic [DATA_WIDTH-1:0] win_rdata;
   logic                  mem_we;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic                  unused_addr_hi;

   assign word_idx       = Address_i[AW+1:2];
   assign win_word       = Address_i[15:2];
   assign unused_addr_hi = ^Address_i[DATA_WIDTH-1:16];

   // The window is decoded per word, so sub-word accesses inside it still hit the register.
   assign hit_out = (win_word == OUT_ADDR[15:2]);
   assign hit_set = (win_word == SET_ADDR[15:2]);
   assign hit_clr = (win_word == CLR_ADDR[15:2]);
   assign hit_in  = (win_word == IN_ADDR[15:2]);
`ifdef GPIO_EDGE_IRQ_EN
   assign hit_edge = (win_word == EDGE_ADDR[15:2]);
`else
   assign hit_edge = 1'b0;
`endif
   assign win_hit = hit_out | hit_set | hit_clr | hit_in | hit_edge;

   assign load_ok  = (Funct3_i == F3_B) || (Funct3_i == F3_BU) || (Funct3_i == F3_H) ||
                     (Funct3_i == F3_HU) || (Funct3_i == F3_W);
   assign store_ok = (Funct3_i == F3_B) || (Funct3_i == F3_H) || (Funct3_i == F3_W);

   assign load_mis  = (((Funct3_i == F3_H) || (Funct3_i == F3_HU)) && Address_i[0]) ||
                      ((Funct3_i == F3_W) && (Address_i[1:0] != 2'b00));
   assign store_mis = ((Funct3_i == F3_H) && Address_i[0]) ||
                      ((Funct3_i == F3_W) && (Address_i[1:0] != 2'b00));

   assign Misaligned_o = (Mem_Read_i && load_mis) || (Mem_Write_i && store_mis);

   assign gpio_wr = Mem_Write_i && (Funct3_i == F3_W) && (Address_i[1:0] == 2'b00) && win_hit;

   // Combinational read sees the pre-edge contents, so a same-cycle store is not forwarded.
   assign rd_word = mem_q[word_idx];
   assign rd_byte = rd_word[{Address_i[1:0], 3'b000} +: 8];
   assign rd_half = rd_word[{Address_i[1], 4'b0000} +: 16];

   always_comb begin
      win_rdata = '0;
      if (hit_out) begin
         win_rdata[GPIO_WIDTH-1:0] = gpio_out_q;
      end else if (hit_in) begin
         win_rdata[GPIO_WIDTH-1:0] = sync2_q;
      end else if (hit_edge) begin
         win_rdata[GPIO_WIDTH-1:0] = edge_rd;
      end
   end

   always_comb begin
      Read_Data_o = '0;
      if (Mem_Read_i && load_ok && !load_mis) begin
         if (win_hit) begin
            Read_Data_o = win_rdata;
         end else begin
            case (Funct3_i)
               F3_B:    Read_Data_o = {{24{rd_byte[7]}}, rd_byte};
               F3_BU:   Read_Data_o = {24'h000000, rd_byte};
               F3_H:    Read_Data_o = {{16{rd_half[15]}}, rd_half};
               F3_HU:   Read_Data_o = {16'h0000, rd_half};
               F3_W:    Read_Data_o = rd_word;
               default: Read_Data_o = '0;
            endcase
         end
      end
   end

   always_comb begin
      mem_we    = 1'b0;
      mem_wdata = rd_word;
      if (!reset && Mem_Write_i && store_ok && !store_mis && !win_hit) begin
         mem_we = 1'b1;
         case (Funct3_i)
            F3_B:    mem_wdata[{Address_i[1:0], 3'b000} +: 8] = Write_Data_i[7:0];
            F3_H:    mem_wdata[{Address_i[1], 4'b0000} +: 16] = Write_Data_i[15:0];
            default: mem_wdata = Write_Data_i;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[word_idx] <= mem_wdata;
      end
   end

   always_comb begin
      gpio_out_d = gpio_out_q;
      if (gpio_wr && hit_out) begin
         gpio_out_d = Write_Data_i[GPIO_WIDTH-1:0];
      end else if (gpio_wr && hit_set) begin
         gpio_out_d = gpio_out_q | Write_Data_i[GPIO_WIDTH-1:0];
      end else if (gpio_wr && hit_clr) begin
         gpio_out_d = gpio_out_q & ~Write_Data_i[GPIO_WIDTH-1:0];
      end
      sync1_d = gpio_port_in;
      sync2_d = sync1_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         gpio_out_q <= GPIO_RESET_VAL;
         sync1_q    <= '0;
         sync2_q    <= '0;
      end else begin
         gpio_out_q <= gpio_out_d;
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
      end
   end

   assign gpio_port_out = gpio_out_q;

`ifdef GPIO_EDGE_IRQ_EN
   logic [GPIO_WIDTH-1:0] sync_prev_q, sync_prev_d;
   logic [GPIO_WIDTH-1:0] edge_q, edge_d;
   logic                  irq_q, irq_d;

   // A rise captured in the same cycle as a write-1-to-clear survives the clear.
   always_comb begin
      sync_prev_d = sync2_q;
      edge_d      = edge_q;
      if (gpio_wr && hit_edge) begin
         edge_d = edge_q & ~Write_Data_i[GPIO_WIDTH-1:0];
      end
      edge_d = edge_d | (sync2_q & ~sync_prev_q);
      irq_d  = |edge_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_prev_q <= '0;
         edge_q      <= '0;
         irq_q       <= 1'b0;
      end else begin
         sync_prev_q <= sync_prev_d;
         edge_q      <= edge_d;
         irq_q       <= irq_d;
      end
   end

   assign edge_rd    = edge_q;
   assign gpio_irq_o = irq_q;
`else
   assign edge_rd    = '0;
   assign gpio_irq_o = 1'b0;
`endif

endmodule
